// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scan controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDoorOpen
    } state_e;

    localparam int unsigned DefNumFloors    = 8;
    localparam int unsigned DefTravelCycles = 10;
    localparam int unsigned DefDoorCycles   = 20;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter that holds at zero; holds its value when neither loaded nor decremented.
module elev_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [Width-1:0] load_val,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches hall/cabin calls, sweeps in one direction
// while requests remain ahead, and dwells with the door open at each requested floor.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = DefNumFloors,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = DefTravelCycles,
    parameter int unsigned DOOR_CYCLES   = DefDoorCycles
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] move_up_call,
    input  logic [NUM_FLOORS-1:0] move_down_call,
    input  logic [NUM_FLOORS-1:0] req_floor,
    input  logic                  open_door,
    input  logic                  close_door,
    input  logic                  over_weight,
    output logic                  door_state,
    output logic                  over_weight_alert,
    output logic [FLOOR_W-1:0]    q,
    output logic                  dir_up,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                      : DOOR_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxCycles + 1);
    // Timers load N-1 so that zero is seen on the Nth cycle of the interval.
    localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_CYCLES - 1);
    localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_CYCLES - 1);

    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    q_q, q_d, q_step;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, clear_mask;
    logic                  door_state_q, moving_q, alert_q;

    logic                  travel_load, travel_dec, travel_zero;
    logic                  door_load, door_dec, door_zero;
    logic [TimerW-1:0]     door_val;
    logic                  any_above, any_below, beyond_step, at_limit;

    elev_timer #(
        .Width (TimerW)
    ) u_travel_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (travel_load),
        .dec      (travel_dec),
        .load_val (TravelLast),
        .zero     (travel_zero)
    );

    elev_timer #(
        .Width (TimerW)
    ) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (door_load),
        .dec      (door_dec),
        .load_val (door_val),
        .zero     (door_zero)
    );

    assign q_step   = dir_up_q ? (q_q + 1'b1) : (q_q - 1'b1);
    assign at_limit = dir_up_q ? (q_q == FLOOR_W'(NUM_FLOORS - 1)) : (q_q == '0);

    always_comb begin
        any_above   = 1'b0;
        any_below   = 1'b0;
        beyond_step = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (i > int'(q_q)) any_above = 1'b1;
                if (i < int'(q_q)) any_below = 1'b1;
                if (dir_up_q ? (i > int'(q_step)) : (i < int'(q_step))) beyond_step = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        dir_up_d    = dir_up_q;
        travel_load = 1'b0;
        travel_dec  = 1'b0;
        door_load   = 1'b0;
        door_dec    = 1'b0;
        door_val    = DoorLast;
        clear_mask  = '0;
        unique case (state_q)
            StIdle: begin
                if (pending_q[q_q] || open_door) begin
                    state_d   = StDoorOpen;
                    door_load = 1'b1;
                end else if (!over_weight) begin
                    if (any_above && (dir_up_q || !any_below)) begin
                        dir_up_d    = 1'b1;
                        state_d     = StMoving;
                        travel_load = 1'b1;
                    end else if (any_below) begin
                        dir_up_d    = 1'b0;
                        state_d     = StMoving;
                        travel_load = 1'b1;
                    end
                end
            end
            StMoving: begin
                if (!travel_zero) begin
                    travel_dec = 1'b1;
                end else begin
                    travel_load = 1'b1;
                    if (at_limit) begin
                        state_d = StIdle;
                    end else begin
                        q_d = q_step;
                        if (pending_q[q_step]) begin
                            state_d   = StDoorOpen;
                            door_load = 1'b1;
                        end else if (!beyond_step) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StDoorOpen: begin
                clear_mask[q_q] = 1'b1;
                // Overload and open button both restart a full dwell.
                if (over_weight || open_door) begin
                    door_load = 1'b1;
                end else if (door_zero) begin
                    state_d = StIdle;
                end else if (close_door) begin
                    door_load = 1'b1;
                    door_val  = '0;
                end else begin
                    door_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        pending_d = (pending_q | move_up_call | move_down_call | req_floor) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            q_q          <= '0;
            dir_up_q     <= 1'b1;
            pending_q    <= '0;
            door_state_q <= 1'b0;
            moving_q     <= 1'b0;
            alert_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            dir_up_q     <= dir_up_d;
            pending_q    <= pending_d;
            door_state_q <= (state_d == StDoorOpen);
            moving_q     <= (state_d == StMoving);
            alert_q      <= over_weight && (state_d != StMoving);
        end
    end

    assign door_state        = door_state_q;
    assign over_weight_alert = alert_q;
    assign q                 = q_q;
    assign dir_up            = dir_up_q;
    assign moving            = moving_q;
    assign pending           = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_elevator_scan_ctrl;

    localparam int N  = 4;
    localparam int TC = 10;
    localparam int DC = 20;
    localparam int ModeIdle = 0;
    localparam int ModeMove = 1;
    localparam int ModeDoor = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] up_call = '0, dn_call = '0, req = '0;
    logic         open_d = 1'b0, close_d = 1'b0, ow = 1'b0;
    logic         door_state, alert, dir_up, moving;
    logic [1:0]   q;
    logic [N-1:0] pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS    (N),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .move_up_call      (up_call),
        .move_down_call    (dn_call),
        .req_floor         (req),
        .open_door         (open_d),
        .close_door        (close_d),
        .over_weight       (ow),
        .door_state        (door_state),
        .over_weight_alert (alert),
        .q                 (q),
        .dir_up            (dir_up),
        .moving            (moving),
        .pending           (pending)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: remaining-cycle counters for travel and dwell.
    bit m_valid = 0;
    int m_floor, m_mode, m_travel, m_dwell;
    bit m_dir, m_alert;
    bit m_pend[N];

    function automatic void model_step();
        bit np[N];
        bit above, below, beyond;
        int nf;
        if (rst) begin
            m_valid = 1; m_floor = 0; m_dir = 1; m_mode = ModeIdle;
            m_travel = 0; m_dwell = 0; m_alert = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            return;
        end
        if (!m_valid) return;
        above = 0; below = 0;
        for (int i = 0; i < N; i++) begin
            np[i] = m_pend[i] | up_call[i] | dn_call[i] | req[i];
            if (m_mode == ModeDoor && i == m_floor) np[i] = 0;
            if (m_pend[i] && i > m_floor) above = 1;
            if (m_pend[i] && i < m_floor) below = 1;
        end
        case (m_mode)
            ModeIdle: begin
                if (m_pend[m_floor] || open_d) begin
                    m_mode = ModeDoor; m_dwell = DC;
                end else if (!ow && above && (m_dir || !below)) begin
                    m_dir = 1; m_mode = ModeMove; m_travel = TC;
                end else if (!ow && below) begin
                    m_dir = 0; m_mode = ModeMove; m_travel = TC;
                end
            end
            ModeMove: begin
                if (m_travel > 1) begin
                    m_travel--;
                end else begin
                    m_travel = TC;
                    nf = m_dir ? m_floor + 1 : m_floor - 1;
                    if (nf < 0 || nf >= N) begin
                        m_mode = ModeIdle;
                    end else begin
                        m_floor = nf;
                        beyond = 0;
                        for (int i = 0; i < N; i++)
                            if (m_pend[i] && (m_dir ? i > nf : i < nf)) beyond = 1;
                        if (m_pend[nf]) begin
                            m_mode = ModeDoor; m_dwell = DC;
                        end else if (!beyond) begin
                            m_mode = ModeIdle;
                        end
                    end
                end
            end
            default: begin
                if (ow || open_d) m_dwell = DC;
                else if (m_dwell == 1) m_mode = ModeIdle;
                else if (close_d) m_dwell = 1;
                else m_dwell--;
            end
        endcase
        for (int i = 0; i < N; i++) m_pend[i] = np[i];
        m_alert = ow && (m_mode != ModeMove);
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] pv;
        model_step();
        #1;
        if (m_valid) begin
            for (int i = 0; i < N; i++) pv[i] = m_pend[i];
            check("outputs{q,dir,mov,door,alert,pend}",
                  32'({q, dir_up, moving, door_state, alert, pending}),
                  32'({2'(m_floor), m_dir, m_mode == ModeMove, m_mode == ModeDoor,
                       m_alert, pv}));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int order[$];
        logic prev_door;

        // Reset state.
        cyc(); cyc();
        check("rst_q", 32'(q), 0);
        check("rst_dir", 32'(dir_up), 1);
        check("rst_moving", 32'(moving), 0);
        check("rst_door", 32'(door_state), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_alert", 32'(alert), 0);
        rst = 1'b0;

        // Ride from 0 to 3.
        req = 4'b1000; cyc(); req = '0;
        check("press_latch", 32'(pending), 32'h8);
        cyc();
        check("depart", 32'(moving), 1);
        n = 0; while (q != 2'd1 && n < 100) begin cyc(); n++; end
        check("travel_0_1", n, 10);
        n = 0; while (q != 2'd2 && n < 100) begin cyc(); n++; end
        check("travel_1_2", n, 10);
        n = 0; while (q != 2'd3 && n < 100) begin cyc(); n++; end
        check("travel_2_3", n, 10);
        check("door_at_3", 32'(door_state), 1);
        n = 0; while (door_state && n < 100) begin cyc(); n++; end
        check("dwell_3", n, 20);
        check("pending_clear_3", 32'(pending), 0);
        check("idle_at_3", 32'({moving, door_state}), 0);

        // Down sweep: stop at 2, then 0.
        dn_call = 4'b0100; req = 4'b0001; cyc(); dn_call = '0; req = '0; cyc();
        check("dir_down", 32'(dir_up), 0);
        n = 0; while (!door_state && n < 100) begin cyc(); n++; end
        check("stop_floor_2", 32'(q), 2);
        check("stop_time_2", n, 10);
        n = 0; while (!(door_state && q == 2'd0) && n < 200) begin cyc(); n++; end
        check("stop_floor_0", 32'({q, dir_up}), 0);
        n = 0; while (door_state && n < 100) begin cyc(); n++; end

        // Mid-sweep new requests: order 2, 3, then 0.
        req = 4'b1000; cyc(); req = '0;
        n = 0; while (q != 2'd1 && n < 100) begin cyc(); n++; end
        req = 4'b0101; cyc(); req = '0;
        prev_door = door_state;
        n = 0;
        while (order.size() < 3 && n < 600) begin
            cyc(); n++;
            if (door_state && !prev_door) order.push_back(int'(q));
            prev_door = door_state;
        end
        check("service_count", order.size(), 3);
        if (order.size() == 3) begin
            check("service_1st", order[0], 2);
            check("service_2nd", order[1], 3);
            check("service_3rd", order[2], 0);
        end
        n = 0; while (door_state && n < 100) begin cyc(); n++; end

        // Door buttons at floor 0.
        open_d = 1'b1; cyc(); open_d = 1'b0;
        check("open_btn", 32'(door_state), 1);
        cyc();
        close_d = 1'b1; cyc(); close_d = 1'b0; cyc();
        check("close_btn", 32'(door_state), 0);
        open_d = 1'b1; cyc(); open_d = 1'b0;
        repeat (14) cyc();
        open_d = 1'b1; cyc(); open_d = 1'b0;
        n = 0; while (door_state && n < 100) begin cyc(); n++; end
        check("reopen_dwell", n, 20);

        // Overload holds the door.
        ow = 1'b1; open_d = 1'b1; cyc(); open_d = 1'b0;
        check("ow_alert", 32'(alert), 1);
        repeat (29) begin
            cyc();
            check("ow_door_held", 32'({door_state, moving}), 32'h2);
        end
        ow = 1'b0;
        n = 0; while (door_state && n < 100) begin cyc(); n++; end
        check("ow_dwell_after", n, 20);
        check("ow_alert_off", 32'(alert), 0);

        // Reset mid-travel between 1 and 2.
        req = 4'b0100; cyc(); req = '0;
        n = 0; while (q != 2'd1 && n < 100) begin cyc(); n++; end
        repeat (5) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_mid", 32'({q, moving, door_state, pending}), 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            up_call = ($urandom_range(0, 24) == 0) ? 4'($urandom) : '0;
            dn_call = ($urandom_range(0, 24) == 0) ? 4'($urandom) : '0;
            req     = ($urandom_range(0, 19) == 0) ? 4'($urandom) : '0;
            open_d  = ($urandom_range(0, 49) == 0);
            close_d = ($urandom_range(0, 29) == 0);
            if (ow) ow = ($urandom_range(0, 14) != 0);
            else    ow = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_FLOORS, 8, number of served floors (>=2).
- FLOOR_W, $clog2(NUM_FLOORS), floor index width (derived).
- TRAVEL_CYCLES, 10, clock cycles to move one floor.
- DOOR_CYCLES, 20, clock cycles the door dwells open.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic rising-edge.
- rst, in, 1, reset, synchronous, active-high.
- move_up_call, in, NUM_FLOORS, hall up buttons, bit i = floor i.
- move_down_call, in, NUM_FLOORS, hall down buttons.
- req_floor, in, NUM_FLOORS, cabin floor buttons.
- open_door, in, 1, cabin door-open button.
- close_door, in, 1, cabin door-close button.
- over_weight, in, 1, load sensor.
- door_state, out, 1, 1 = door open.
- over_weight_alert, out, 1, overload indicator.
- q, out, FLOOR_W, current floor, binary.
- dir_up, out, 1, travel direction, 1 = up.
- moving, out, 1, cabin between floors.
- pending, out, NUM_FLOORS, latched outstanding requests.

Function
REQ-003 pending[i] SHALL set on the edge after any of move_up_call[i], move_down_call[i] or req_floor[i] is sampled high; a press visible one cycle later.
REQ-004 pending[i] SHALL clear only while state is DOOR_OPEN and q==i; a press at q during DOOR_OPEN is absorbed, with clear taking priority over set.
REQ-005 The FSM SHALL have states IDLE, MOVING, DOOR_OPEN; outputs registered.
REQ-006 IDLE: pending[q] or open_door -> DOOR_OPEN; else pending above q and (dir_up or none below) -> dir_up=1, MOVING; else pending below -> dir_up=0, MOVING; else stay.
REQ-007 IDLE SHALL not leave for MOVING while over_weight=1.
REQ-008 MOVING: travel counter counts TRAVEL_CYCLES; at expiry q steps +/-1 by dir_up, counter reloads.
REQ-009 On arrival: pending[new q] -> DOOR_OPEN; else pending beyond q in dir_up -> stay MOVING; else -> IDLE.
REQ-010 q SHALL never leave 0..NUM_FLOORS-1; a step past a boundary is suppressed and the FSM goes to IDLE.
REQ-011 In MOVING, open_door, close_door and over_weight SHALL be ignored; moving=1 only in MOVING.
REQ-012 DOOR_OPEN: door_state=1; door timer loads DOOR_CYCLES on entry, decrements per cycle; at zero with over_weight=0 -> IDLE with door_state=0.
REQ-013 open_door in DOOR_OPEN SHALL reload the timer; close_door SHALL zero it; both asserted together -> open_door wins.
REQ-014 over_weight=1 in DOOR_OPEN SHALL hold the timer at DOOR_CYCLES; when it drops the dwell restarts full.
REQ-015 over_weight_alert SHALL equal over_weight registered, gated to states IDLE and DOOR_OPEN.

Reset
REQ-016 On rst sampled high: state IDLE, q=0, dir_up=1, moving=0, door_state=0, over_weight_alert=0, pending=0, both counters 0; presses in a reset cycle are discarded.
REQ-017 Reset mid-MOVING or mid-DOOR_OPEN SHALL take effect on that edge with no residual motion or request.

Structure
REQ-018 Package elevator_pkg SHALL hold the state enum and default parameter constants.
REQ-019 One sub-module elev_timer (loadable, holdable down-counter, zero flag) SHALL be instanced twice: travel and door.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=10, DOOR_CYCLES=20)
REQ-020 After reset, req_floor=4'b1000 one cycle -> q 1,2,3 at 10-cycle spacing, door_state=1 at 3, pending=0, door closes 20 cycles later, IDLE.
REQ-021 Idle at 3, move_down_call=4'b0100 and req_floor=4'b0001 -> stops at 2 (door 20 cycles), then 0; dir_up=0 throughout.
REQ-022 Moving up past 1 toward 3, press req_floor=4'b0101 -> service order 2, 3, then 0.
REQ-023 Door open at 0: close_door pulse -> door_state=0 within 2 cycles; open_door pulse at dwell cycle 15 -> door open 20 further cycles.
REQ-024 over_weight held 30 cycles in DOOR_OPEN -> over_weight_alert=1, door open for 30+20 cycles; no motion while asserted.
REQ-025 rst pulse mid-travel between floors 1 and 2 -> next cycle q=0, moving=0, pending=0, door_state=0.
